r2048x8_arb_ctl: RTL and testbench
==================================

# r2048x8_arb_ctl

Single-clock controller that shares one 2048x8 block RAM (separate write and read ports, WClk = RClk = Clk, unregistered read output) between two requesters. Write and read ports are arbitrated independently with round-robin fairness. Same-cycle write/read to one address is forwarded. A clear sequencer initialises every location to a constant after reset or on command. Sits between two client datapaths and the RAM macro wrapper.

## Interface
- CLR_VAL, 8'h00, value written to every address during a clear sweep
- CLR_ON_RESET, 1, 1 = enter CLEAR after reset; 0 = enter RUN directly
- Clk  in  1  single clock; also drives RAM WClk and RClk
- Rst_n  in  1  reset, asynchronous, active-low
- req0, req1  in  1  operation request, held until granted
- we0, we1  in  1  1 = write, 0 = read; qualifies reqN
- addr0, addr1  in  11  word address
- wd0, wd1  in  8  write data
- gnt0, gnt1  out  1  combinational; operation accepted this cycle
- rvalid0, rvalid1  out  1  registered; rdata carries requester N's read result
- rdata  out  8  shared read-return data
- clr_req  in  1  start a clear sweep (sampled in RUN only)
- busy  out  1  registered; 1 while in CLEAR
- ram_wa, ram_ra  out  11  RAM write/read address
- ram_wd  out  8  RAM write data
- ram_wen  out  1  RAM write enable, active-high
- ram_wclk_en, ram_rclk_en  out  1  RAM clock enables: ram_wclk_en = ram_wen, ram_rclk_en = read granted
- ram_rd  in  8  RAM read data, valid the cycle after the RA edge

## Operation
- FSM states: CLEAR, RUN.
  - Reset → CLEAR with clr_addr = 0 if CLR_ON_RESET = 1, else → RUN.
- CLEAR:
  - Each cycle: ram_wen = 1, ram_wa = clr_addr, ram_wd = CLR_VAL, clr_addr++.
  - At clr_addr = 2047 the write occurs and state → RUN. A full sweep is exactly 2048 cycles.
  - gnt0 = gnt1 = 0. No reads are issued. clr_req is ignored (no restart).
- RUN:
  - clr_req = 1 → CLEAR next cycle, clr_addr = 0. Grants in that same cycle are still issued normally.
- Write-port arbitration:
  - Candidates are requesters with reqN & weN.
  - One candidate: it is granted.
  - Both: the requester indicated by wr_ptr is granted, then wr_ptr flips to the other requester.
  - A grant with only one candidate also sets wr_ptr to the non-granted requester.
- Read-port arbitration: identical rule on candidates reqN & ~weN, with its own rd_ptr.
- One requester may win write while the other wins read in the same cycle. Both are granted.
- Read return:
  - The cycle after a read grant to N: rvalid N = 1, other rvalid = 0.
  - rdata = ram_rd, or the bypass register if forwarding.
- Forwarding: a write and a read granted in the same cycle with ram_wa == ram_ra → next cycle rdata = the write data, not ram_rd.
- Write in cycle k, read of the same address granted in k+1 → RAM supplies the new data (no forwarding needed).
- A read granted in the cycle clr_req is taken completes normally: rvalid asserts in the first CLEAR cycle.

## Timing
- Reset values:
  - rvalid0 = rvalid1 = 0, rdata = 8'h00.
  - wr_ptr = rd_ptr = 0 (requester 0 favoured).
  - busy = CLR_ON_RESET, clr_addr = 0, bypass flag = 0.
- gnt, ram_wa/ra/wd, ram_wen and clock enables are combinational from req/we/addr/state. They are 0/don't-care-free: addresses and data are 0 when unused.
- Read latency: grant cycle k → rvalid/rdata at cycle k+1. Throughput: 1 read + 1 write per cycle.
- busy rises the cycle after clr_req is taken. It falls the cycle after the clr_addr = 2047 write.
- Reset assertion mid-sweep aborts immediately. Deassertion restarts the sweep from address 0.

## Test plan
- Reset with CLR_ON_RESET = 1 → busy = 1 for 2048 cycles, ram_wa steps 0..2047 with ram_wd = 8'h00, no gnt. A later read of addr 11'h7FF returns 8'h00.
- Both requesters write continuously (addr0 = 5, wd0 = 8'hA5; addr1 = 6, wd1 = 8'h5A) → grants alternate 0,1,0,1 starting with 0. Subsequent reads return A5 and 5A.
- Req0 writes 8'h3C to addr 100 while req1 reads addr 100 in the same cycle → both granted. Next cycle rvalid1 = 1, rdata = 8'h3C.
- Req0 reads addr 7 while req1 writes addr 8 → both granted the same cycle. rvalid0 the next cycle with the stored value.
- clr_req pulsed with a read granted the same cycle → rvalid asserts during the first CLEAR cycle with the pre-clear data. Then 2048 busy cycles; clr_req pulses during CLEAR do not extend the sweep.
- Rst_n asserted at clr_addr = 1000 → outputs go to reset values asynchronously. After release the sweep restarts at 0 and lasts 2048 cycles.

Source files
------------

// File: rtl/r2048x8_arb_ctl.sv
// Two-requester controller for a shared 2048x8 RAM: independent round-robin write and read
// arbitration, same-cycle write/read forwarding, and a clear sequencer that sweeps every word.
module r2048x8_arb_ctl #(
    parameter logic [7:0] CLR_VAL      = 8'h00,
    parameter bit         CLR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [10:0] addr0,
    input  logic [10:0] addr1,
    input  logic [7:0]  wd0,
    input  logic [7:0]  wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [7:0]  rdata,
    input  logic        clr_req,
    output logic        busy,
    output logic [10:0] ram_wa,
    output logic [10:0] ram_ra,
    output logic [7:0]  ram_wd,
    output logic        ram_wen,
    output logic        ram_wclk_en,
    output logic        ram_rclk_en,
    input  logic [7:0]  ram_rd
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLR_ON_RESET ? S_CLEAR : S_RUN;

    state_t      state_reg, state_next;
    logic [10:0] clr_addr_reg, clr_addr_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic [1:0]  rvalid_reg;
    logic        byp_flag_reg;
    logic [7:0]  byp_data_reg;

    logic [1:0]  req_v, we_v;
    logic [1:0]  wr_cand, rd_cand;
    logic [1:0]  wr_gnt, rd_gnt;
    logic        run;
    logic        fwd_hit;

    assign run   = (state_reg == S_RUN);
    assign req_v = {req1, req0};
    assign we_v  = {we1, we0};

    // Per-requester candidates; on contention the pointer picks the winner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            assign wr_cand[gi] = run & req_v[gi] & we_v[gi];
            assign rd_cand[gi] = run & req_v[gi] & ~we_v[gi];
            assign wr_gnt[gi]  = wr_cand[gi] & (~wr_cand[1-gi] | (wr_ptr_reg == 1'(gi)));
            assign rd_gnt[gi]  = rd_cand[gi] & (~rd_cand[1-gi] | (rd_ptr_reg == 1'(gi)));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        ram_wa        = '0;
        ram_wd        = '0;
        ram_wen       = 1'b0;
        ram_ra        = '0;
        case (state_reg)
            S_CLEAR: begin
                ram_wen       = 1'b1;
                ram_wa        = clr_addr_reg;
                ram_wd        = CLR_VAL;
                clr_addr_next = clr_addr_reg + 11'd1;
                if (clr_addr_reg == 11'h7FF) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (clr_req) begin
                    state_next    = S_CLEAR;
                    clr_addr_next = '0;
                end
                if (|wr_gnt) begin
                    ram_wen     = 1'b1;
                    ram_wa      = wr_gnt[0] ? addr0 : addr1;
                    ram_wd      = wr_gnt[0] ? wd0 : wd1;
                    wr_ptr_next = wr_gnt[0];
                end
                if (|rd_gnt) begin
                    ram_ra      = rd_gnt[0] ? addr0 : addr1;
                    rd_ptr_next = rd_gnt[0];
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // The RAM returns pre-write data on a same-address collision, so capture the write data.
    assign fwd_hit = (|wr_gnt) & (|rd_gnt) & (ram_wa == ram_ra);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= RESET_STATE;
            clr_addr_reg <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            rvalid_reg   <= '0;
            byp_flag_reg <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            rvalid_reg   <= rd_gnt;
            byp_flag_reg <= fwd_hit;
            if (fwd_hit) begin
                byp_data_reg <= ram_wd;
            end
        end
    end

    assign gnt0        = wr_gnt[0] | rd_gnt[0];
    assign gnt1        = wr_gnt[1] | rd_gnt[1];
    assign rvalid0     = rvalid_reg[0];
    assign rvalid1     = rvalid_reg[1];
    assign rdata       = (|rvalid_reg) ? (byp_flag_reg ? byp_data_reg : ram_rd) : 8'h00;
    assign busy        = (state_reg == S_CLEAR);
    assign ram_wclk_en = ram_wen;
    assign ram_rclk_en = |rd_gnt;

endmodule

// File: tb/tb_r2048x8_arb_ctl.sv
// Bench for r2048x8_arb_ctl: directed stimulus pushes expected reads into a scoreboard,
// a negedge monitor pops and compares on every rvalid.
module tb_r2048x8_arb_ctl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        req0, req1, we0, we1, clr_req;
    logic [10:0] addr0, addr1;
    logic [7:0]  wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0]  rdata;
    logic [10:0] ram_wa, ram_ra;
    logic [7:0]  ram_wd;
    logic        ram_wen, ram_wclk_en, ram_rclk_en;
    logic [7:0]  ram_rd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    r2048x8_arb_ctl #(.CLR_VAL(8'h00), .CLR_ON_RESET(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .clr_req(clr_req), .busy(busy),
        .ram_wa(ram_wa), .ram_ra(ram_ra), .ram_wd(ram_wd), .ram_wen(ram_wen),
        .ram_wclk_en(ram_wclk_en), .ram_rclk_en(ram_rclk_en), .ram_rd(ram_rd)
    );

    // RAM macro model: read-before-write, data available the cycle after the read edge.
    logic [7:0] mem [2048];
    always @(posedge Clk) begin
        if (ram_wclk_en && ram_wen) mem[ram_wa] <= ram_wd;
        if (ram_rclk_en) ram_rd <= mem[ram_ra];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && (rvalid0 === 1'b1 || rvalid1 === 1'b1)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=%b%b rdata=%h expected none",
                         rvalid1, rvalid0, rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] read return req%0d rdata=%h (expect req%0d %h)",
                         rvalid1, rdata, e.id, e.data);
                chk("rvalid_id", 32'({rvalid1, rvalid0}), 32'(e.id ? 2'b10 : 2'b01));
                chk("rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic push(input bit id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [10:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [10:0] a1, input logic [7:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wd1 = d1;
    endtask

    task automatic tick(input string name, input logic g0, input logic g1);
        #1;
        $display("[TB] op %s gnt=%b%b (expect %b%b)", name, gnt1, gnt0, g1, g0);
        chk({name, "_gnt"}, 32'({gnt1, gnt0}), 32'({g1, g0}));
        @(posedge Clk);
        #1;
    endtask

    // Walks a clear sweep, checking write address/data and that nothing is granted.
    task automatic sweep(input string name, input int stop_at, input int exp_cnt, input bit pulse);
        int cnt = 0;
        bit bad = 1'b0;
        while (busy === 1'b1 && cnt < stop_at) begin
            if (ram_wen !== 1'b1 || ram_wa !== cnt[10:0] || ram_wd !== 8'h00 ||
                gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                bad = 1'b1;
            end
            clr_req = pulse && (cnt == 100 || cnt == 2047);
            cnt++;
            @(posedge Clk);
            #1;
        end
        clr_req = 1'b0;
        $display("[TB] sweep %s cycles=%0d (expect %0d)", name, cnt, exp_cnt);
        chk({name, "_sweep_writes_ok"}, 32'(bad), 32'(0));
        chk({name, "_sweep_cycles"}, 32'(cnt), 32'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n   = 1'b0;
        clr_req = 1'b0;
        // Read of 7FF held through the power-on sweep; granted on the first RUN cycle.
        drive(1, 0, 11'h7FF, 8'h00, 0, 0, 11'h000, 8'h00);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'(0));
        Rst_n = 1'b1;
        #1;
        sweep("init", 3000, 2048, 1'b0);

        push(0, 8'h00); tick("rd_7ff", 1, 0);

        drive(1, 1, 11'd5, 8'hA5, 1, 1, 11'd6, 8'h5A);
        tick("wr_alt_a", 1, 0);
        tick("wr_alt_b", 0, 1);
        tick("wr_alt_c", 1, 0);
        tick("wr_alt_d", 0, 1);

        drive(1, 0, 11'd5, 8'h00, 0, 0, 11'd0, 8'h00); push(0, 8'hA5); tick("rd_5", 1, 0);
        drive(0, 0, 11'd0, 8'h00, 1, 0, 11'd6, 8'h00); push(1, 8'h5A); tick("rd_6", 0, 1);

        drive(1, 1, 11'd100, 8'h3C, 1, 0, 11'd100, 8'h00); push(1, 8'h3C); tick("fwd_100", 1, 1);

        drive(1, 1, 11'd7, 8'hC3, 0, 0, 11'd0, 8'h00); tick("wr_7", 1, 0);
        drive(1, 0, 11'd7, 8'h00, 1, 1, 11'd8, 8'h88); push(0, 8'hC3); tick("rd7_wr8", 1, 1);
        drive(1, 1, 11'd9, 8'h99, 0, 0, 11'd0, 8'h00); tick("wr_9", 1, 0);
        drive(0, 0, 11'd0, 8'h00, 1, 0, 11'd9, 8'h00); push(1, 8'h99); tick("rd_9_next", 0, 1);
        drive(0, 0, 11'd0, 8'h00, 1, 0, 11'd8, 8'h00); push(1, 8'h88); tick("rd_8", 0, 1);

        drive(1, 0, 11'd5, 8'h00, 1, 0, 11'd6, 8'h00);
        push(0, 8'hA5); tick("rd_both_a", 1, 0);
        push(1, 8'h5A); tick("rd_both_b", 0, 1);

        // Read granted in the same cycle the clear is taken.
        drive(1, 0, 11'd6, 8'h00, 0, 0, 11'd0, 8'h00);
        clr_req = 1'b1;
        push(0, 8'h5A); tick("clr_rd", 1, 0);
        clr_req = 1'b0;
        drive(0, 0, 11'd0, 8'h00, 0, 0, 11'd0, 8'h00);
        chk("clr_busy_rise", 32'(busy), 32'(1));
        sweep("cmd", 3000, 2048, 1'b1);
        chk("clr_busy_fall", 32'(busy), 32'(0));

        drive(1, 0, 11'd5, 8'h00, 0, 0, 11'd0, 8'h00); push(0, 8'h00); tick("rd_5_clr", 1, 0);
        drive(0, 0, 11'd0, 8'h00, 1, 0, 11'd100, 8'h00); push(1, 8'h00); tick("rd_100_clr", 0, 1);

        // Reset in the middle of a sweep, then a full restart from address 0.
        drive(0, 0, 11'd0, 8'h00, 0, 0, 11'd0, 8'h00);
        clr_req = 1'b1;
        tick("clr2", 0, 0);
        clr_req = 1'b0;
        sweep("pre_rst", 1000, 1000, 1'b0);
        chk("mid_sweep_wa", 32'(ram_wa), 32'(1000));
        Rst_n = 1'b0;
        #1;
        chk("async_rst_wa", 32'(ram_wa), 32'(0));
        chk("async_rst_busy", 32'(busy), 32'(1));
        chk("async_rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        chk("async_rst_rdata", 32'(rdata), 32'(0));
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        #1;
        sweep("post_rst", 3000, 2048, 1'b0);

        drive(1, 1, 11'd20, 8'h11, 1, 1, 11'd21, 8'h22); tick("wr_ptr_rst", 1, 0);
        drive(0, 0, 11'd0, 8'h00, 1, 0, 11'd6, 8'h00); push(1, 8'h00); tick("rd_6_rst", 0, 1);

        drive(0, 0, 11'd0, 8'h00, 0, 0, 11'd0, 8'h00);
        repeat (3) @(posedge Clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
